psram_bist_seq: RTL
===================

// Module: psram_bist_seq
// PURPOSE
// - Upstream request generator for the PSRAM controller: built-in self-test sequencer.
// - On i_start, writes an LFSR pattern to N_WORDS consecutive 16-bit locations,
//   then re-seeds, reads every location back and compares.
// - Reports the following:
//   - pass/fail and timeout status,
//   - error count,
//   - address and read data of the first miscompare.
// - Sits between the board top (buttons/LEDs/UART status) and the PSRAM controller's strobe port.
// PARAMETERS
// - START_ADDR   24'h000000  first word address tested
// - N_WORDS      1024        number of words tested (1..2^24-START_ADDR)
// - SEED         16'hACE1    LFSR seed, must be non-zero
// - TIMEOUT_CYC  4096        max i_clk cycles allowed per transaction
// PORTS
// - i_clk              in   1   system clock (100 MHz)
// - arst_n             in   1   asynchronous, active-low reset
// - i_start            in   1   1-cycle pulse: begin test (ignored unless o_busy=0)
// - o_busy             out  1   test in progress
// - o_pass             out  1   last test completed with zero errors
// - o_fail             out  1   last test completed with >=1 error
// - o_timeout          out  1   last test aborted: controller did not complete in time
// - o_err_cnt          out  16  miscompare count, saturates at 16'hFFFF
// - o_first_err_addr   out  24  address of first miscompare
// - o_first_err_data   out  16  data read at first miscompare
// - o_stb              out  1   request strobe to controller, 1-cycle pulse
// - o_we               out  1   1=write, 0=read; held with o_addr/o_din until done
// - o_addr             out  24  word address, stable from o_stb until transaction done
// - o_din              out  16  write data, stable from o_stb until transaction done
// - i_ctrl_busy        in   1   controller busy
// - i_ctrl_done        in   1   controller done (level; drops on accept, rises on completion)
// - i_ctrl_dout        in   16  read data, valid when i_ctrl_done rises after a read
// BEHAVIOUR
// - Reset
//   - All outputs 0; state IDLE; LFSR=SEED; address=START_ADDR.
//   - Reset mid-test aborts immediately.
//   - o_stb must be 0 during reset regardless of controller state.
// - LFSR
//   - 16-bit Fibonacci, taps 16,14,13,11; shifts once per transaction issued.
//   - Write and read phases both start from SEED, so word k is compared against the k-th LFSR value.
// - Address increments by 1 per word; no wrap (N_WORDS bounded by parameter).
// - FSM states: IDLE, WAIT_RDY, WR_ISSUE, WR_ACK, WR_WAIT, RD_ISSUE, RD_ACK, RD_WAIT, CHECK, FINISH.
//   - IDLE: i_start -> clear pass/fail/timeout/err_cnt/first_err_*; o_busy=1; -> WAIT_RDY.
//   - WAIT_RDY: wait i_ctrl_done=1 && i_ctrl_busy=0 (controller init complete) -> WR_ISSUE.
//   - WR_ISSUE: drive o_stb=1 for exactly 1 cycle, o_we=1, o_addr, o_din=LFSR -> WR_ACK.
//   - WR_ACK: wait i_ctrl_done=0 (accepted) -> WR_WAIT.
//   - WR_WAIT: wait i_ctrl_done=1 -> next addr/LFSR. Last word -> reload SEED/START_ADDR, RD_ISSUE; else WR_ISSUE.
//   - RD_ISSUE: same as WR_ISSUE with o_we=0 -> RD_ACK -> RD_WAIT.
//   - RD_WAIT: wait i_ctrl_done=1 -> CHECK (sample i_ctrl_dout this cycle).
//   - CHECK: compare sampled data to LFSR.
//     - On mismatch: err_cnt+1 (saturating); if err_cnt was 0, capture first_err addr/data.
//     - Advance; last word -> FINISH; else RD_ISSUE.
//   - FINISH: o_pass=(err_cnt==0), o_fail=~o_pass, o_busy=0 -> IDLE. Status held until next i_start.
// - Timeout
//   - Counter clears on every o_stb.
//   - If ACK+WAIT together exceed TIMEOUT_CYC cycles: o_timeout=1, o_fail=1, o_pass=0, o_busy=0 -> IDLE.
// - Handshake rules
//   - Never assert o_stb while i_ctrl_done=0 or i_ctrl_busy=1.
//   - At most one outstanding transaction.
//   - o_addr/o_we/o_din change only in *_ISSUE or after done rises.
// - i_start while o_busy=1: ignored.
// - i_start same cycle as FINISH: ignored; status still published.
// - Throughput per word = controller latency + 2 cycles (ISSUE, ACK-detect) + 1 (CHECK) for reads.
// TESTING
// - Bench: psram_bist_seq + PSRAM controller + behavioural QPI PSRAM model (two x4 chips).
// - Reset, N_WORDS=16, pulse i_start after controller init -> 16 writes then 16 reads.
//   Expect o_pass=1, o_err_cnt=0, o_busy falls.
// - Model corrupts read of addr 5 (bit0 flipped) -> o_fail=1, o_err_cnt=1,
//   o_first_err_addr=24'h000005, o_first_err_data = expected LFSR word 5 ^ 16'h0001.
// - Model stuck-at-0 on all data -> o_err_cnt=16, o_first_err_addr=START_ADDR.
// - Model never returns done (TIMEOUT_CYC=64) -> o_timeout=1, o_fail=1 within 64+3 cycles of o_stb.
// - Pulse i_start before controller init done -> no o_stb until i_ctrl_done=1 && i_ctrl_busy=0.
// - Assert arst_n=0 during read phase -> all outputs 0 next edge.
//   After release, a new i_start runs a clean full test to o_pass=1.

Source files
------------

// File: rtl/psram_bist_seq.sv
// PSRAM BIST sequencer: writes an LFSR pattern over a word range, reads it back and compares.
// Latency: one ISSUE cycle, then controller latency plus one ACK cycle per word; reads add one CHECK cycle.
// Backpressure: strobes only when the controller is idle with done high; at most one transaction outstanding.
module psram_bist_seq #(
    parameter logic [23:0] START_ADDR  = 24'h000000,
    parameter int          N_WORDS     = 1024,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic        i_clk,
    input  logic        arst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_pass,
    output logic        o_fail,
    output logic        o_timeout,
    output logic [15:0] o_err_cnt,
    output logic [23:0] o_first_err_addr,
    output logic [15:0] o_first_err_data,
    output logic        o_stb,
    output logic        o_we,
    output logic [23:0] o_addr,
    output logic [15:0] o_din,
    input  logic        i_ctrl_busy,
    input  logic        i_ctrl_done,
    input  logic [15:0] i_ctrl_dout
);
    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, WR_ISSUE, WR_ACK, WR_WAIT,
        RD_ISSUE, RD_ACK, RD_WAIT, CHECK, FINISH
    } state_t;

    localparam int CW = 25;
    localparam int TW = $clog2(TIMEOUT_CYC + 2);

    state_t        state, state_nxt;
    logic [23:0]   addr, addr_nxt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [15:0]   rd_dat;
    logic [CW-1:0] word_cnt, word_cnt_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          last_word, waiting, tmo_hit, mismatch;
    logic          start_acc, advance, rewind, load_out, out_we, capture, finish, abort;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    assign last_word = (word_cnt == CW'(N_WORDS - 1));
    assign waiting   = state inside {WR_ACK, WR_WAIT, RD_ACK, RD_WAIT};
    assign tmo_hit   = (tmo_cnt >= TW'(TIMEOUT_CYC));
    assign mismatch  = (state == CHECK) && (rd_dat != lfsr);

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_stb     = 1'b0;
        start_acc = 1'b0;
        advance   = 1'b0;
        rewind    = 1'b0;
        load_out  = 1'b0;
        out_we    = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                start_acc = 1'b1;
                state_nxt = WAIT_RDY;
            end
            WAIT_RDY: if (i_ctrl_done && !i_ctrl_busy) begin
                load_out  = 1'b1;
                out_we    = 1'b1;
                state_nxt = WR_ISSUE;
            end
            WR_ISSUE, RD_ISSUE: if (i_ctrl_done && !i_ctrl_busy) begin
                o_stb     = 1'b1;
                state_nxt = (state == WR_ISSUE) ? WR_ACK : RD_ACK;
            end
            WR_ACK, RD_ACK: begin
                if (!i_ctrl_done) state_nxt = (state == WR_ACK) ? WR_WAIT : RD_WAIT;
                else if (tmo_hit) abort = 1'b1;
            end
            WR_WAIT: begin
                if (i_ctrl_done) begin
                    load_out = 1'b1;
                    if (last_word) begin
                        rewind    = 1'b1;
                        state_nxt = RD_ISSUE;
                    end else begin
                        advance   = 1'b1;
                        out_we    = 1'b1;
                        state_nxt = WR_ISSUE;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_ctrl_done) begin
                    capture   = 1'b1;
                    state_nxt = CHECK;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            CHECK: begin
                if (last_word) begin
                    state_nxt = FINISH;
                end else begin
                    advance   = 1'b1;
                    load_out  = 1'b1;
                    state_nxt = RD_ISSUE;
                end
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Read phase replays the write sequence: rewind restores seed and base address.
    always_comb begin
        addr_nxt     = addr;
        lfsr_nxt     = lfsr;
        word_cnt_nxt = word_cnt;
        if (rewind) begin
            addr_nxt     = START_ADDR;
            lfsr_nxt     = SEED;
            word_cnt_nxt = '0;
        end else if (advance) begin
            addr_nxt     = addr + 24'd1;
            lfsr_nxt     = lfsr_step(lfsr);
            word_cnt_nxt = word_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            addr             <= START_ADDR;
            lfsr             <= SEED;
            word_cnt         <= '0;
            rd_dat           <= '0;
            tmo_cnt          <= '0;
            o_busy           <= 1'b0;
            o_pass           <= 1'b0;
            o_fail           <= 1'b0;
            o_timeout        <= 1'b0;
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
            o_we             <= 1'b0;
            o_addr           <= '0;
            o_din            <= '0;
        end else begin
            if (start_acc) begin
                addr             <= START_ADDR;
                lfsr             <= SEED;
                word_cnt         <= '0;
                o_busy           <= 1'b1;
                o_pass           <= 1'b0;
                o_fail           <= 1'b0;
                o_timeout        <= 1'b0;
                o_err_cnt        <= '0;
                o_first_err_addr <= '0;
                o_first_err_data <= '0;
            end else begin
                addr     <= addr_nxt;
                lfsr     <= lfsr_nxt;
                word_cnt <= word_cnt_nxt;
            end
            if (load_out) begin
                o_addr <= addr_nxt;
                o_din  <= lfsr_nxt;
                o_we   <= out_we;
            end
            if (o_stb)                   tmo_cnt <= '0;
            else if (waiting && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            if (capture) rd_dat <= i_ctrl_dout;
            if (mismatch) begin
                if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
                if (o_err_cnt == 16'd0) begin
                    o_first_err_addr <= addr;
                    o_first_err_data <= rd_dat;
                end
            end
            if (finish) begin
                o_busy <= 1'b0;
                o_pass <= (o_err_cnt == 16'd0);
                o_fail <= (o_err_cnt != 16'd0);
            end
            if (abort) begin
                o_busy    <= 1'b0;
                o_pass    <= 1'b0;
                o_fail    <= 1'b1;
                o_timeout <= 1'b1;
            end
        end
    end
endmodule
